kcore_mem_arbiter: RTL and testbench

Single-outstanding arbiter sharing one memory port between the kcore instruction-fetch (imem) and data (dmem) interfaces. It sits between kcore and a single-ported memory model or SRAM, in the formal wrapper and the simulation top. It latches the winning request, drives a req/gnt plus rvalid handshake toward memory, and returns a one-cycle ready pulse with read data to the owner. A watchdog keeps a silent memory from hanging the core.

---
 rtl/kcore_mem_arb_pkg.sv | 26 ++
 rtl/kcore_arb_pick.sv | 25 ++
 rtl/kcore_mem_arbiter.sv | 177 +++++++++++++++++
 tb/tb_kcore_mem_arbiter.sv | 293 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/kcore_mem_arb_pkg.sv
// kcore_mem_arb_pkg: shared types for the kcore memory arbiter.
//   arb_state_e : arbiter FSM states (IDLE/REQ/WAIT/RESP)
//   owner_e     : which kcore interface owns the current transaction
//   mem_req_t   : latched request fields presented on the memory port
package kcore_mem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2,
    RESP = 2'd3
  } arb_state_e;

  typedef enum logic {
    OWN_IMEM = 1'b0,
    OWN_DMEM = 1'b1
  } owner_e;

  typedef struct packed {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
  } mem_req_t;

endpackage

// File: rtl/kcore_arb_pick.sv
// kcore_arb_pick: combinational 2-way grant picker.
//   imem_valid, dmem_valid : pending requests
//   last_owner             : owner of the most recent grant made in IDLE
//   rr_en                  : 1 = round-robin on contention, 0 = dmem priority
//   owner                  : selected owner (don't-care when neither is valid)
module kcore_arb_pick
  import kcore_mem_arb_pkg::*;
(
  input  logic   imem_valid,
  input  logic   dmem_valid,
  input  owner_e last_owner,
  input  logic   rr_en,
  output owner_e owner
);

  always_comb begin
    owner = OWN_DMEM;
    if (imem_valid && !dmem_valid) begin
      owner = OWN_IMEM;
    end else if (imem_valid && dmem_valid && rr_en && (last_owner == OWN_DMEM)) begin
      owner = OWN_IMEM;
    end
  end

endmodule

// File: rtl/kcore_mem_arbiter.sv
// kcore_mem_arbiter: single-outstanding arbiter sharing one memory port
// between the kcore fetch (imem) and data (dmem) interfaces.
//   clock, reset          : rising-edge clock, synchronous active-high reset
//   imem_*                : fetch request / one-cycle ready with read data
//   dmem_*                : load/store request / one-cycle ready with read data
//   mem_*                 : req/gnt + rvalid handshake toward memory
//   arb_timeout           : sticky watchdog flag, cleared only by reset
// Parameter TIMEOUT: REQ+WAIT cycles allowed before forced completion (0 = off).
// Macro KCORE_MEM_ARB_RR_EN: round-robin on contention instead of dmem priority.
// All outputs come from flops or from state decode only.
module kcore_mem_arbiter
  import kcore_mem_arb_pkg::*;
#(
  parameter int unsigned TIMEOUT = 64
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        imem_valid,
  input  logic [31:0] imem_addr,
  output logic [31:0] imem_rdata,
  output logic        imem_ready,
  input  logic        dmem_valid,
  input  logic        dmem_write,
  input  logic [31:0] dmem_addr,
  input  logic [31:0] dmem_wdata,
  input  logic [3:0]  dmem_wstrb,
  output logic [31:0] dmem_rdata,
  output logic        dmem_ready,
  output logic        mem_req,
  input  logic        mem_gnt,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_wstrb,
  input  logic        mem_rvalid,
  input  logic [31:0] mem_rdata,
  output logic        arb_timeout
);

  localparam int unsigned CW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [CW-1:0] CNT_LIM = CW'(TIMEOUT);

  arb_state_e  state_q, state_d;
  owner_e      owner_q, owner_d;
  mem_req_t    req_q, req_d;
  logic [31:0] rsp_q, rsp_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic        timeout_q, timeout_d;

  logic [CW-1:0] cnt_inc;
  logic          wd_fire;
  owner_e        pick_owner;

`ifdef KCORE_MEM_ARB_RR_EN
  owner_e last_q, last_d;

  kcore_arb_pick u_pick (
    .imem_valid (imem_valid),
    .dmem_valid (dmem_valid),
    .last_owner (last_q),
    .rr_en      (1'b1),
    .owner      (pick_owner)
  );
`else
  kcore_arb_pick u_pick (
    .imem_valid (imem_valid),
    .dmem_valid (dmem_valid),
    .last_owner (OWN_IMEM),
    .rr_en      (1'b0),
    .owner      (pick_owner)
  );
`endif

  // Saturating watchdog; it fires in the cycle whose count reaches TIMEOUT,
  // so REQ+WAIT together last at most TIMEOUT cycles.
  always_comb begin
    cnt_inc = (cnt_q == '1) ? cnt_q : cnt_q + CW'(1);
    wd_fire = (TIMEOUT != 0) && (cnt_inc == CNT_LIM);
  end

  always_comb begin
    state_d   = state_q;
    owner_d   = owner_q;
    req_d     = req_q;
    rsp_d     = rsp_q;
    cnt_d     = cnt_q;
    timeout_d = timeout_q;
`ifdef KCORE_MEM_ARB_RR_EN
    last_d    = last_q;
`endif
    case (state_q)
      IDLE: begin
        if (imem_valid || dmem_valid) begin
          owner_d = pick_owner;
          state_d = REQ;
          cnt_d   = '0;
`ifdef KCORE_MEM_ARB_RR_EN
          last_d  = pick_owner;
`endif
          if (pick_owner == OWN_DMEM) begin
            req_d = '{we: dmem_write, addr: dmem_addr, wdata: dmem_wdata, wstrb: dmem_wstrb};
          end else begin
            req_d = '{we: 1'b0, addr: imem_addr, wdata: '0, wstrb: '0};
          end
        end
      end
      REQ: begin
        cnt_d = cnt_inc;
        if (wd_fire) begin
          state_d   = RESP;
          rsp_d     = '0;
          timeout_d = 1'b1;
        end else if (mem_gnt) begin
          state_d = WAIT;
        end
      end
      WAIT: begin
        cnt_d = cnt_inc;
        // A response landing in the final allowed cycle still completes normally.
        if (mem_rvalid) begin
          state_d = RESP;
          rsp_d   = req_q.we ? '0 : mem_rdata;
        end else if (wd_fire) begin
          state_d   = RESP;
          rsp_d     = '0;
          timeout_d = 1'b1;
        end
      end
      RESP: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q   <= IDLE;
      owner_q   <= OWN_IMEM;
      req_q     <= '0;
      rsp_q     <= '0;
      cnt_q     <= '0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      owner_q   <= owner_d;
      req_q     <= req_d;
      rsp_q     <= rsp_d;
      cnt_q     <= cnt_d;
      timeout_q <= timeout_d;
    end
  end

`ifdef KCORE_MEM_ARB_RR_EN
  always_ff @(posedge clock) begin
    if (reset) begin
      last_q <= OWN_IMEM;
    end else begin
      last_q <= last_d;
    end
  end
`endif

  assign mem_req     = (state_q == REQ);
  assign mem_we      = req_q.we;
  assign mem_addr    = req_q.addr;
  assign mem_wdata   = req_q.wdata;
  assign mem_wstrb   = req_q.wstrb;
  assign imem_ready  = (state_q == RESP) && (owner_q == OWN_IMEM);
  assign dmem_ready  = (state_q == RESP) && (owner_q == OWN_DMEM);
  assign imem_rdata  = rsp_q;
  assign dmem_rdata  = rsp_q;
  assign arb_timeout = timeout_q;

endmodule

// File: tb/tb_kcore_mem_arbiter.sv
// tb_kcore_mem_arbiter: self-checking bench for kcore_mem_arbiter (TIMEOUT=8).
// A reactive memory model answers with programmable gnt/rvalid delays; the
// expected latency, data, owner and sticky flag come from a transaction-level
// model of the arbiter's rules.
module tb_kcore_mem_arbiter;

  localparam int T = 8;

  logic        clk;
  logic        reset;
  logic        imem_valid;
  logic [31:0] imem_addr;
  logic [31:0] imem_rdata;
  logic        imem_ready;
  logic        dmem_valid;
  logic        dmem_write;
  logic [31:0] dmem_addr;
  logic [31:0] dmem_wdata;
  logic [3:0]  dmem_wstrb;
  logic [31:0] dmem_rdata;
  logic        dmem_ready;
  logic        mem_req;
  logic        mem_gnt;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_wstrb;
  logic        mem_rvalid;
  logic [31:0] mem_rdata;
  logic        arb_timeout;

  kcore_mem_arbiter #(.TIMEOUT(T)) dut (
    .clock       (clk),
    .reset       (reset),
    .imem_valid  (imem_valid),
    .imem_addr   (imem_addr),
    .imem_rdata  (imem_rdata),
    .imem_ready  (imem_ready),
    .dmem_valid  (dmem_valid),
    .dmem_write  (dmem_write),
    .dmem_addr   (dmem_addr),
    .dmem_wdata  (dmem_wdata),
    .dmem_wstrb  (dmem_wstrb),
    .dmem_rdata  (dmem_rdata),
    .dmem_ready  (dmem_ready),
    .mem_req     (mem_req),
    .mem_gnt     (mem_gnt),
    .mem_we      (mem_we),
    .mem_addr    (mem_addr),
    .mem_wdata   (mem_wdata),
    .mem_wstrb   (mem_wstrb),
    .mem_rvalid  (mem_rvalid),
    .mem_rdata   (mem_rdata),
    .arb_timeout (arb_timeout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_vec = 0;
  int n_mis = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_mis++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] memval(input logic [31:0] a);
    return (a == 32'h100) ? 32'hDEADBEEF : ((a * 32'h9E3779B1) ^ 32'h5A5AA5A5);
  endfunction

  // Memory model controls and expected request fields.
  int          m_gdel = 0;
  int          m_rdel = 0;
  bit          m_norv = 1'b0;
  bit          chk_en = 1'b0;
  logic        exp_we;
  logic [31:0] exp_addr;
  logic [31:0] exp_wdata;
  logic [3:0]  exp_wstrb;

  // Arbiter model state.
  bit model_sticky = 1'b0;
  bit m_last_d     = 1'b0;

  // Reactive memory: gnt after m_gdel mem_req cycles, rvalid m_rdel cycles
  // after the cycle following gnt. Abandons its transaction on any ready.
  initial begin
    int          ph = 0;
    int          gc = 0;
    int          rc = 0;
    logic [31:0] ma = '0;
    mem_gnt    = 1'b0;
    mem_rvalid = 1'b0;
    mem_rdata  = '0;
    forever begin
      @(negedge clk);
      mem_rdata = $urandom;
      if (imem_ready || dmem_ready) begin
        ph = 0; gc = 0; mem_gnt = 1'b0; mem_rvalid = 1'b0;
      end else if (ph == 0) begin
        mem_rvalid = 1'b0;
        mem_gnt    = 1'b0;
        if (mem_req) begin
          if (chk_en) begin
            check("mem_we", {31'd0, mem_we}, {31'd0, exp_we});
            check("mem_addr", mem_addr, exp_addr);
            check("mem_wstrb", {28'd0, mem_wstrb}, {28'd0, exp_wstrb});
            if (exp_we) check("mem_wdata", mem_wdata, exp_wdata);
          end
          if (gc == m_gdel) begin
            mem_gnt = 1'b1; ma = mem_addr; ph = 1; rc = 0; gc = 0;
          end else begin
            gc++;
          end
        end
      end else begin
        mem_gnt = 1'b0;
        if (!m_norv && rc == m_rdel) begin
          mem_rvalid = 1'b1; mem_rdata = memval(ma); ph = 0;
        end else begin
          rc++;
        end
      end
    end
  end

  task automatic wait_ready(output int n);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!(imem_ready || dmem_ready) && n < 40);
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, "_imem_ready"}, {31'd0, imem_ready}, 32'd0);
    check({tag, "_dmem_ready"}, {31'd0, dmem_ready}, 32'd0);
    check({tag, "_mem_req"}, {31'd0, mem_req}, 32'd0);
    check({tag, "_timeout"}, {31'd0, arb_timeout}, 32'd0);
    check({tag, "_imem_rdata"}, imem_rdata, 32'd0);
    check({tag, "_dmem_rdata"}, dmem_rdata, 32'd0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1; imem_valid = 1'b0; dmem_valid = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    model_sticky = 1'b0;
    m_last_d     = 1'b0;
    check_idle_outputs("post_reset");
  endtask

  // One isolated transaction; expectations from the timing rules:
  // REQ lasts g+1 cycles, WAIT r+1, forced completion on the T-th counted cycle.
  task automatic run_txn(input bit d, input bit we, input logic [31:0] addr,
                         input logic [31:0] wd, input logic [3:0] ws,
                         input int g, input int r, input bit norv);
    bit          to;
    int          lat;
    int          n;
    logic [31:0] exp;
    to  = (g + 1 >= T) || norv || (g + r + 2 > T);
    lat = to ? T + 1 : g + r + 3;
    exp = (to || (d && we)) ? 32'd0 : memval(addr);
    model_sticky = model_sticky | to;
    m_last_d     = d;
    m_gdel = g; m_rdel = r; m_norv = norv; chk_en = 1'b1;
    exp_we = d && we; exp_addr = addr; exp_wdata = wd; exp_wstrb = d ? ws : 4'd0;
    @(negedge clk);
    if (d) begin
      dmem_valid = 1'b1; dmem_write = we; dmem_addr = addr; dmem_wdata = wd; dmem_wstrb = ws;
    end else begin
      imem_valid = 1'b1; imem_addr = addr;
    end
    wait_ready(n);
    check("latency", n, lat);
    check("ready_owner", {30'd0, dmem_ready, imem_ready}, d ? 32'd2 : 32'd1);
    check("imem_rdata", imem_rdata, exp);
    check("dmem_rdata", dmem_rdata, exp);
    check("arb_timeout", {31'd0, arb_timeout}, {31'd0, model_sticky});
    imem_valid = 1'b0; dmem_valid = 1'b0;
    @(negedge clk);
    check("ready_pulse", {30'd0, dmem_ready, imem_ready}, 32'd0);
    check("idle_mem_req", {31'd0, mem_req}, 32'd0);
    chk_en = 1'b0;
  endtask

  // Both interfaces valid continuously; the served one keeps valid high with
  // a fresh request, dmem drops out after four grants.
  task automatic contend();
    logic [31:0] da;
    int          n;
    bit          wd;
    m_gdel = 0; m_rdel = 0; m_norv = 1'b0; chk_en = 1'b0;
    @(negedge clk);
    da = 32'h400;
    imem_addr = 32'h300; imem_valid = 1'b1;
    dmem_valid = 1'b1; dmem_write = 1'b0; dmem_addr = da; dmem_wdata = '0; dmem_wstrb = 4'hF;
    for (int t = 0; t < 5; t++) begin
      if (t == 4) wd = 1'b0;
      else begin
`ifdef KCORE_MEM_ARB_RR_EN
        wd = !m_last_d;
`else
        wd = 1'b1;
`endif
      end
      wait_ready(n);
      check("ctn_latency", n, (t == 0) ? 32'd3 : 32'd4);
      check("ctn_owner", {30'd0, dmem_ready, imem_ready}, wd ? 32'd2 : 32'd1);
      check("ctn_rdata", wd ? dmem_rdata : imem_rdata, wd ? memval(da) : memval(32'h300));
      m_last_d = wd;
      if (wd) begin
        da = da + 32'd4; dmem_addr = da;
      end
      if (t == 3) dmem_valid = 1'b0;
    end
    imem_valid = 1'b0; dmem_valid = 1'b0;
    @(negedge clk);
    check("ctn_ready_pulse", {30'd0, dmem_ready, imem_ready}, 32'd0);
  endtask

  initial begin
    #2000000;
    $display("FAIL global_time_limit: got expired expected finish");
    $fatal(1, "time limit");
  end

  initial begin
    reset = 1'b1;
    imem_valid = 1'b0; imem_addr = '0;
    dmem_valid = 1'b0; dmem_write = 1'b0; dmem_addr = '0; dmem_wdata = '0; dmem_wstrb = '0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    check_idle_outputs("reset");
    check("reset_mem_we", {31'd0, mem_we}, 32'd0);
    check("reset_mem_addr", mem_addr, 32'd0);
    check("reset_mem_wdata", mem_wdata, 32'd0);
    check("reset_mem_wstrb", {28'd0, mem_wstrb}, 32'd0);

    run_txn(1'b0, 1'b0, 32'h100, 32'h0, 4'h0, 0, 0, 1'b0);
    run_txn(1'b1, 1'b1, 32'h204, 32'h1234, 4'b0011, 0, 0, 1'b0);
    run_txn(1'b1, 1'b0, 32'h208, 32'h0, 4'hF, 1, 2, 1'b0);
    run_txn(1'b1, 1'b0, 32'h20C, 32'h0, 4'b1010, 5, 0, 1'b0);

    do_reset();
    contend();

    run_txn(1'b0, 1'b0, 32'h600, 32'h0, 4'h0, 0, 0, 1'b1);
    run_txn(1'b1, 1'b1, 32'h604, 32'hCAFE, 4'hF, 0, 1, 1'b0);
    run_txn(1'b0, 1'b0, 32'h608, 32'h0, 4'h0, 2, 4, 1'b0);
    run_txn(1'b1, 1'b0, 32'h60C, 32'h0, 4'hF, 7, 0, 1'b0);
    do_reset();

    // Reset while waiting for rvalid; the late response must be ignored.
    m_gdel = 0; m_rdel = 3; m_norv = 1'b0; chk_en = 1'b1;
    exp_we = 1'b0; exp_addr = 32'h500; exp_wdata = '0; exp_wstrb = 4'h0;
    @(negedge clk);
    imem_valid = 1'b1; imem_addr = 32'h500;
    repeat (2) @(negedge clk);
    reset = 1'b1; imem_valid = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    model_sticky = 1'b0; m_last_d = 1'b0; chk_en = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      check("rst_no_ready", {30'd0, dmem_ready, imem_ready}, 32'd0);
      check("rst_idle", {31'd0, mem_req}, 32'd0);
    end
    run_txn(1'b0, 1'b0, 32'h504, 32'h0, 4'h0, 0, 0, 1'b0);

    for (int k = 0; k < 40; k++) begin
      bit          d;
      bit          we;
      logic [31:0] a;
      a  = {$urandom_range(0, 65535), 2'b00};
      d  = $urandom_range(0, 1) == 1;
      we = $urandom_range(0, 1) == 1;
      run_txn(d, we, a, $urandom, 4'($urandom_range(0, 15)),
              $urandom_range(0, 5), $urandom_range(0, 4), $urandom_range(0, 9) == 0);
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
    $finish;
  end

endmodule
